stage_pipe: RTL and testbench

- Parametrised valid/ready pipeline stage buffer. It is the generic successor to the fixed per-stage bus registers (D/X/M/W) in the npc core.
- Carries an opaque WIDTH-bit payload through a DEPTH-entry elastic buffer.
- Adds a synchronous flush for branch/trap squash, a combinational passthrough mode, and stall/occupancy statistics.
- One instance sits between each pair of adjacent pipeline stages.

---
 rtl/stage_pipe.sv | 131 +++++++++++++
 tb/tb_stage_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_pipe.sv
// stage_pipe: valid/ready elastic buffer placed between adjacent pipeline stages.
// It carries an opaque WIDTH-bit payload and has two build-time modes:
//   MODE 0 - DEPTH-entry FIFO. The payload is read combinationally from storage.
//   MODE 1 - combinational passthrough with no storage.
// It also supports a synchronous flush (squash) and keeps stall and occupancy statistics.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   flush      synchronous squash of all held and incoming beats
//   clr_stats  synchronous clear of stall_cnt and max_count
//   s_valid / s_ready / s_data   upstream handshake and payload
//   m_valid / m_ready / m_data   downstream handshake and payload
//   count      current occupancy (always 0 in passthrough)
//   max_count  high-water mark of count since the last clear
//   stall_cnt  saturating count of cycles with m_valid=1 and m_ready=0
module stage_pipe #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 2,
   parameter  int MODE  = 0,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             clr_stats,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] max_count,
   output logic [31:0]      stall_cnt
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [CNT_W-1:0] cntQ;
   logic [CNT_W-1:0] cntNext;
   logic [CNT_W-1:0] maxCnt;
   logic [31:0]      stallCnt;

   generate
      if (MODE == 0) begin : gBuf
         logic [WIDTH-1:0] mem [DEPTH];
         logic [PTR_W-1:0] rdPtr;
         logic [PTR_W-1:0] wrPtr;
         logic             push;
         logic             pop;

         // DEPTH need not be a power of two, so wrap is an explicit compare.
         function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
            return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
         endfunction

         // s_ready looks only at occupancy, never at m_ready. When the buffer
         // is full, it waits a cycle after a pop before it accepts again.
         assign s_ready = rst & (cntQ != CNT_W'(DEPTH));
         assign m_valid = (cntQ != '0);
         assign m_data  = mem[rdPtr];
         assign push    = s_valid & s_ready;
         assign pop     = m_valid & m_ready;

         always_comb begin
            cntNext = cntQ;
            if (flush)
               cntNext = '0;
            else if (push && !pop)
               cntNext = cntQ + CNT_W'(1);
            else if (pop && !push)
               cntNext = cntQ - CNT_W'(1);
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               cntQ  <= '0;
               rdPtr <= '0;
               wrPtr <= '0;
            end else begin
               cntQ <= cntNext;
               if (flush) begin
                  rdPtr <= '0;
                  wrPtr <= '0;
               end else begin
                  if (push) wrPtr <= nextPtr(wrPtr);
                  if (pop)  rdPtr <= nextPtr(rdPtr);
               end
            end
         end

         // Storage is not reset. Contents are ignored while the buffer is empty.
         always_ff @(posedge clk) begin
            if (push && !flush)
               mem[wrPtr] <= s_data;
         end
      end else begin : gPass
         assign m_valid = s_valid & ~flush;
         assign s_ready = m_ready & rst;
         assign m_data  = s_data;
         assign cntQ    = '0;
         assign cntNext = '0;
      end
   endgenerate

   // The high-water mark tracks the post-edge occupancy. A clear re-seeds it
   // from that occupancy rather than from zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         maxCnt <= '0;
      else if (clr_stats)
         maxCnt <= cntNext;
      else if (cntNext > maxCnt)
         maxCnt <= cntNext;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stallCnt <= '0;
      else if (clr_stats)
         stallCnt <= '0;
      else if (m_valid && !m_ready && (stallCnt != 32'hFFFF_FFFF))
         stallCnt <= stallCnt + 32'd1;
   end

   assign count     = cntQ;
   assign max_count = maxCnt;
   assign stall_cnt = stallCnt;

endmodule

// File: tb/tb_stage_pipe.sv
// Directed bench for stage_pipe. It uses three instances:
//   u_d2 - MODE 0, DEPTH 2 (streaming)
//   u_d3 - MODE 0, DEPTH 3 (stall, wrap, flush, reset, statistics)
//   u_pt - MODE 1 (passthrough)
module tb_stage_pipe;

   logic clk;
   logic rst;
   logic flush;
   logic clrStats;

   logic        aValid, aReady, aMValid, aMReady;
   logic [31:0] aData, aMData, aStall;
   logic [1:0]  aCount, aMax;

   logic        bValid, bReady, bMValid, bMReady;
   logic [31:0] bData, bMData, bStall;
   logic [1:0]  bCount, bMax;

   logic        cValid, cReady, cMValid, cMReady;
   logic [31:0] cData, cMData, cStall;
   logic [1:0]  cCount, cMax;

   int checks   = 0;
   int failures = 0;

   stage_pipe #(.WIDTH(32), .DEPTH(2), .MODE(0)) u_d2 (
      .clk(clk), .rst(rst), .flush(flush), .clr_stats(clrStats),
      .s_valid(aValid), .s_ready(aReady), .s_data(aData),
      .m_valid(aMValid), .m_ready(aMReady), .m_data(aMData),
      .count(aCount), .max_count(aMax), .stall_cnt(aStall)
   );

   stage_pipe #(.WIDTH(32), .DEPTH(3), .MODE(0)) u_d3 (
      .clk(clk), .rst(rst), .flush(flush), .clr_stats(clrStats),
      .s_valid(bValid), .s_ready(bReady), .s_data(bData),
      .m_valid(bMValid), .m_ready(bMReady), .m_data(bMData),
      .count(bCount), .max_count(bMax), .stall_cnt(bStall)
   );

   stage_pipe #(.WIDTH(32), .DEPTH(2), .MODE(1)) u_pt (
      .clk(clk), .rst(rst), .flush(flush), .clr_stats(clrStats),
      .s_valid(cValid), .s_ready(cReady), .s_data(cData),
      .m_valid(cMValid), .m_ready(cMReady), .m_data(cMData),
      .count(cCount), .max_count(cMax), .stall_cnt(cStall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs;
      flush = 0; clrStats = 0;
      aValid = 0; aData = '0; aMReady = 0;
      bValid = 0; bData = '0; bMReady = 0;
      cValid = 0; cData = '0; cMReady = 0;
   endtask

   task automatic do_reset;
      idle_inputs();
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      idle_inputs();
      cMReady = 1;
      rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (aCount !== 2'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", aCount); end
      checks++; if (aMValid !== 1'b0) begin failures++; $display("FAIL rst_mvalid got=%b exp=0", aMValid); end
      checks++; if (aReady !== 1'b0) begin failures++; $display("FAIL rst_sready_d2 got=%b exp=0", aReady); end
      checks++; if (bReady !== 1'b0) begin failures++; $display("FAIL rst_sready_d3 got=%b exp=0", bReady); end
      checks++; if (cReady !== 1'b0) begin failures++; $display("FAIL rst_sready_pt got=%b exp=0", cReady); end
      checks++; if (aStall !== 32'd0) begin failures++; $display("FAIL rst_stall got=%h exp=0", aStall); end
      checks++; if (aMax !== 2'd0) begin failures++; $display("FAIL rst_max got=%0d exp=0", aMax); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (aReady !== 1'b1) begin failures++; $display("FAIL rel_sready_d2 got=%b exp=1", aReady); end
      checks++; if (bReady !== 1'b1) begin failures++; $display("FAIL rel_sready_d3 got=%b exp=1", bReady); end
      checks++; if (cReady !== 1'b1) begin failures++; $display("FAIL rel_sready_pt got=%b exp=1", cReady); end
      @(posedge clk); #1;
   endtask

   task automatic test_stream;
      logic [31:0] vals [3];
      vals = '{32'h11, 32'h22, 32'h33};
      do_reset();
      aMReady = 1;
      aValid  = 1;
      for (int i = 0; i < 3; i++) begin
         aData = vals[i];
         @(posedge clk); #1;
         checks++; if (aMValid !== 1'b1 || aMData !== vals[i]) begin failures++; $display("FAIL stream_data%0d got=%h/%b exp=%h/1", i, aMData, aMValid, vals[i]); end
         checks++; if (aCount !== 2'd1) begin failures++; $display("FAIL stream_count%0d got=%0d exp=1", i, aCount); end
         checks++; if (aReady !== 1'b1) begin failures++; $display("FAIL stream_sready%0d got=%b exp=1", i, aReady); end
      end
      aValid = 0;
      @(posedge clk); #1;
      checks++; if (aMValid !== 1'b0) begin failures++; $display("FAIL stream_drained got=%b exp=0", aMValid); end
      checks++; if (aStall !== 32'd0) begin failures++; $display("FAIL stream_stall got=%0d exp=0", aStall); end
      checks++; if (aMax !== 2'd1) begin failures++; $display("FAIL stream_max got=%0d exp=1", aMax); end
   endtask

   task automatic test_stall_drain;
      do_reset();
      bMReady = 0;
      bValid = 1; bData = 32'hA;
      @(posedge clk); #1;
      bData = 32'hB;
      @(posedge clk); #1;
      bData = 32'hC;
      @(posedge clk); #1;
      bValid = 0;
      checks++; if (bCount !== 2'd3) begin failures++; $display("FAIL full_count got=%0d exp=3", bCount); end
      checks++; if (bReady !== 1'b0) begin failures++; $display("FAIL full_sready got=%b exp=0", bReady); end
      checks++; if (bMax !== 2'd3) begin failures++; $display("FAIL full_max got=%0d exp=3", bMax); end
      checks++; if (bMData !== 32'hA) begin failures++; $display("FAIL full_head got=%h exp=a", bMData); end
      checks++; if (bStall !== 32'd2) begin failures++; $display("FAIL stall_a got=%0d exp=2", bStall); end
      @(posedge clk); #1;
      checks++; if (bStall !== 32'd3) begin failures++; $display("FAIL stall_b got=%0d exp=3", bStall); end
      @(posedge clk); #1;
      bMReady = 1;
      #1;
      checks++; if (bReady !== 1'b0) begin failures++; $display("FAIL full_no_comb_ready got=%b exp=0", bReady); end
      @(posedge clk); #1;
      checks++; if (bMData !== 32'hB || bCount !== 2'd2) begin failures++; $display("FAIL drain_b got=%h/%0d exp=b/2", bMData, bCount); end
      checks++; if (bReady !== 1'b1) begin failures++; $display("FAIL drain_sready got=%b exp=1", bReady); end
      checks++; if (bStall !== 32'd4) begin failures++; $display("FAIL stall_c got=%0d exp=4", bStall); end
      @(posedge clk); #1;
      checks++; if (bMData !== 32'hC || bCount !== 2'd1) begin failures++; $display("FAIL drain_c got=%h/%0d exp=c/1", bMData, bCount); end
      @(posedge clk); #1;
      checks++; if (bMValid !== 1'b0 || bCount !== 2'd0) begin failures++; $display("FAIL drain_empty got=%b/%0d exp=0/0", bMValid, bCount); end
      checks++; if (bStall !== 32'd4 || bMax !== 2'd3) begin failures++; $display("FAIL drain_stats got=%0d/%0d exp=4/3", bStall, bMax); end
      clrStats = 1;
      @(posedge clk); #1;
      clrStats = 0;
      checks++; if (bMax !== 2'd0 || bStall !== 32'd0) begin failures++; $display("FAIL clr_stats got=%0d/%0d exp=0/0", bMax, bStall); end
   endtask

   task automatic test_wrap;
      int  nextPush;
      int  expPop;
      logic pushed;
      do_reset();
      nextPush = 1;
      expPop   = 1;
      for (int cyc = 0; cyc < 40 && expPop <= 7; cyc++) begin
         bValid  = (nextPush <= 7);
         bData   = 32'(nextPush);
         bMReady = cyc[0];
         #1;
         pushed = bValid & bReady;
         if (bMValid && bMReady) begin
            checks++;
            if (bMData !== 32'(expPop)) begin failures++; $display("FAIL wrap_order got=%0d exp=%0d", bMData, expPop); end
            expPop++;
         end
         @(posedge clk); #1;
         if (pushed) nextPush++;
      end
      bValid = 0; bMReady = 0;
      checks++; if (expPop != 8) begin failures++; $display("FAIL wrap_timeout got=%0d exp=8", expPop - 1); end
   endtask

   task automatic test_flush;
      do_reset();
      bMReady = 0;
      bValid = 1; bData = 32'h41;
      @(posedge clk); #1;
      bData = 32'h42;
      @(posedge clk); #1;
      checks++; if (bCount !== 2'd2) begin failures++; $display("FAIL flush_pre got=%0d exp=2", bCount); end
      flush = 1; bData = 32'h99;
      @(posedge clk); #1;
      flush = 0; bValid = 0;
      checks++; if (bCount !== 2'd0 || bMValid !== 1'b0) begin failures++; $display("FAIL flush_post got=%0d/%b exp=0/0", bCount, bMValid); end
      bMReady = 1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++; if (bMValid !== 1'b0) begin failures++; $display("FAIL flush_leak%0d got=%b/%h exp=0", i, bMValid, bMData); end
      end
      bMReady = 0;
      bValid = 1; bData = 32'h77;
      @(posedge clk); #1;
      bValid = 0;
      checks++; if (bMValid !== 1'b1 || bMData !== 32'h77 || bCount !== 2'd1) begin failures++; $display("FAIL flush_resume got=%b/%h/%0d exp=1/77/1", bMValid, bMData, bCount); end
   endtask

   task automatic test_passthrough;
      do_reset();
      cValid = 1; cData = 32'h5A; cMReady = 1;
      #1;
      checks++; if (cMValid !== 1'b1 || cMData !== 32'h5A) begin failures++; $display("FAIL pt_data got=%b/%h exp=1/5a", cMValid, cMData); end
      checks++; if (cReady !== 1'b1) begin failures++; $display("FAIL pt_ready1 got=%b exp=1", cReady); end
      @(posedge clk); #1;
      cMReady = 0;
      #1;
      checks++; if (cReady !== 1'b0 || cMValid !== 1'b1) begin failures++; $display("FAIL pt_ready0 got=%b/%b exp=0/1", cReady, cMValid); end
      @(posedge clk); #1;
      checks++; if (cStall !== 32'd1) begin failures++; $display("FAIL pt_stall got=%0d exp=1", cStall); end
      flush = 1;
      #1;
      checks++; if (cMValid !== 1'b0) begin failures++; $display("FAIL pt_flush got=%b exp=0", cMValid); end
      checks++; if (cCount !== 2'd0 || cMax !== 2'd0) begin failures++; $display("FAIL pt_count got=%0d/%0d exp=0/0", cCount, cMax); end
      @(posedge clk); #1;
      flush = 0; cMReady = 1;
      #1;
      checks++; if (cStall !== 32'd1 || cReady !== 1'b1) begin failures++; $display("FAIL pt_after got=%0d/%b exp=1/1", cStall, cReady); end
      cValid = 0;
   endtask

   task automatic test_async_reset;
      do_reset();
      bMReady = 0;
      bValid = 1; bData = 32'h1;
      @(posedge clk); #1;
      bData = 32'h2;
      @(posedge clk); #1;
      bValid = 0;
      checks++; if (bCount !== 2'd2) begin failures++; $display("FAIL areset_pre got=%0d exp=2", bCount); end
      #2;
      rst = 1'b0;
      #1;
      checks++; if (bMValid !== 1'b0 || bReady !== 1'b0 || bCount !== 2'd0) begin failures++; $display("FAIL areset_now got=%b/%b/%0d exp=0/0/0", bMValid, bReady, bCount); end
      #2;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (bReady !== 1'b1 || bMValid !== 1'b0) begin failures++; $display("FAIL areset_rel got=%b/%b exp=1/0", bReady, bMValid); end
   endtask

   task automatic test_stall_saturate;
      do_reset();
      bMReady = 0;
      bValid = 1; bData = 32'h5;
      @(posedge clk); #1;
      bValid = 0;
      force u_d3.stallCnt = 32'hFFFF_FFFF;
      #1;
      release u_d3.stallCnt;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         checks++; if (bStall !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_hold%0d got=%h exp=ffffffff", i, bStall); end
      end
      clrStats = 1;
      @(posedge clk); #1;
      clrStats = 0;
      checks++; if (bStall !== 32'd0) begin failures++; $display("FAIL sat_clear got=%h exp=0", bStall); end
      @(posedge clk); #1;
      checks++; if (bStall !== 32'd1) begin failures++; $display("FAIL sat_resume got=%h exp=1", bStall); end
   endtask

   initial begin
      idle_inputs();
      rst = 1'b0;
      test_reset();
      test_stream();
      test_stall_drain();
      test_wrap();
      test_flush();
      test_passthrough();
      test_async_reset();
      test_stall_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
